rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one single-port, synchronous-read ROM between two requesters.
- Each requester has a valid/ready request channel (address) and a valid/ready response channel (data).
- Round-robin arbitration; one transaction in flight at a time.
- Sits between client logic (e.g. two table-lookup FSMs) and a ROM whose registered output updates on the rising edge after the address is presented.

Parameters:
- ADDR_W, 3, ROM address width (ROM depth = 2**ADDR_W words)
- DATA_W, 2, ROM word width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an address to read
- req0_addr  input  ADDR_W  requester 0 read address
- req0_ready  output  1  arbiter accepts requester 0 request this cycle
- rsp0_valid  output  1  response data for requester 0 available
- rsp0_data  output  DATA_W  read data for requester 0
- rsp0_ready  input  1  requester 0 accepts response
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: same as requester 0, for requester 1
- rom_addr  output  ADDR_W  registered address driven to the ROM
- rom_rd  input  DATA_W  ROM registered read data; valid one clk edge after rom_addr changes
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, prio=0, gnt=0, rom_addr=0, data register=0.
  - All ready, valid and busy outputs are 0.
  - Reset mid-transaction aborts the transaction; the response is discarded.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one valid: that requester gets ready.
  - Both valid: requester number prio gets ready.
  - None valid: no ready.
  - reqN_ready is combinational from the valids, state and prio. Requesters must not make valid depend on ready.
- IDLE, on handshake (valid & ready):
  - rom_addr <= reqN_addr, gnt <= N, prio <= ~N, next state ISSUE.
  - A non-granted valid request stays pending; its requester must hold valid and addr stable until accepted.
- ISSUE: ROM samples rom_addr at the end of this cycle. Next state CAPTURE.
- CAPTURE: rom_rd is valid. Data register <= rom_rd; next state RESP.
- RESP:
  - rsp<gnt>_valid = 1 and rsp<gnt>_data = data register. The other rsp valid is 0.
  - Held stable until rsp<gnt>_ready; then next state IDLE.
- Hold rules:
  - rom_addr holds its value outside the IDLE handshake.
  - rspN_data holds the last captured word and is don't-care while rspN_valid=0.
  - reqN_ready = 0 in every state except IDLE.
- Latency: with a handshake in cycle t, rsp_valid rises in cycle t+3. With rsp_ready already high, the next request is accepted at the earliest in cycle t+4. Maximum throughput is 1 read per 4 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- A requester that is alone always wins, regardless of prio; prio still toggles to the opposite of the winner.
- Response backpressure: the FSM stalls in RESP indefinitely. Requests arriving meanwhile wait and are not dropped.
- Address wrap: the address is used as-is. Addresses 0 and 2**ADDR_W-1 need no special handling.

Test Plan (bench ROM model: registered read, contents 0..7 = 00,01,10,11,11,10,01,00):
- Reset: hold rst_n=0, then deassert -> all ready/valid/busy are 0, rom_addr=0. Assert rst_n=0 while in CAPTURE -> immediate IDLE, no rsp_valid afterwards.
- Single read: req0 addr=3, rsp0_ready=1 -> rsp0_valid in cycle t+3 with data=11, rsp1_valid stays 0, busy high cycles t+1..t+3.
- Contention: req0 addr=1 and req1 addr=6 valid together from reset -> req0 served first (data 01), then req1 (data 01 from addr 6). Grant order over 4 back-to-back pairs is 0,1,0,1.
- Backpressure: req1 addr=2, rsp1_ready low for 5 cycles -> rsp1_valid=1, data=10 held stable, req0 (addr 7) not accepted until the cycle after rsp1 handshake, then returns 00.
- Lone requester: req1 only, addresses 0 then 7, back-to-back -> both granted to 1 (data 00, 00), each accepted 4 cycles apart, req0_ready never 1.
- Stall hold: assert req0_valid during ISSUE -> req0_ready=0 until IDLE, and rom_addr is unchanged during ISSUE/CAPTURE/RESP.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// Request/response channels between two ROM clients and the shared-ROM arbiter.
//   req<N>_valid/addr/ready : address channel for requester N
//   rsp<N>_valid/data/ready : read-data channel for requester N
// Modports: master = client side (both requesters), slave = arbiter side.
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 2
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_ready;

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between two requesters.
// One read in flight at a time: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
// Ports:
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of rom_read_arbiter_if (two req/rsp channel pairs)
//   rom_addr : registered address to the ROM
//   rom_rd   : ROM registered read data, valid one edge after rom_addr
//   busy     : high in any state other than IDLE
module rom_read_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_read_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state;
  state_t            state_d;
  logic              prio;
  logic              gnt;
  logic [DATA_W-1:0] rd_data_p2;
  logic              ready0;
  logic              ready1;
  logic              hs0;
  logic              hs1;
  logic              rsp_hs;

  // A lone requester wins outright; prio only breaks ties.
  assign ready0 = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio);
  assign ready1 = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || prio);
  assign hs0    = ready0 && bus.req0_valid;
  assign hs1    = ready1 && bus.req1_valid;
  assign rsp_hs = gnt ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (hs0 || hs1) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = ready0;
    bus.req1_ready = ready1;
    bus.rsp0_valid = (state == RESP) && !gnt;
    bus.rsp1_valid = (state == RESP) && gnt;
    bus.rsp0_data  = rd_data_p2;
    bus.rsp1_data  = rd_data_p2;
    busy           = (state != IDLE);
  end

  // Grant/address latch at the IDLE handshake; ROM data capture in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      gnt        <= 1'b0;
      rom_addr   <= '0;
      rd_data_p2 <= '0;
    end else begin
      if (hs0) begin
        rom_addr <= bus.req0_addr;
        gnt      <= 1'b0;
        prio     <= 1'b1;
      end else if (hs1) begin
        rom_addr <= bus.req1_addr;
        gnt      <= 1'b1;
        prio     <= 1'b0;
      end
      if (state == CAPTURE) begin
        rd_data_p2 <= rom_rd;
      end
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd = '0;
  logic              busy;
  logic [DATA_W-1:0] rom [8];

  rom_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_rd <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  int exp0[$];
  int exp1[$];
  int got_order[$];
  int last_hs1 = -1;
  bit r0_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (exp0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else chk("rsp0_data", int'(bus.rsp0_data), exp0.pop_front());
        got_order.push_back(0);
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (exp1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else chk("rsp1_data", int'(bus.rsp1_data), exp1.pop_front());
        got_order.push_back(1);
        last_hs1 = cyc;
      end
      if (bus.req0_ready) r0_seen = 1;
    end
  end

  // Issue one request; acc returns the cycle in which the handshake happened.
  task automatic send(input int n, input logic [ADDR_W-1:0] a, input int d,
                      input bit push, output int acc);
    acc = -1;
    if (n == 0) begin bus.req0_valid = 1'b1; bus.req0_addr = a; end
    else        begin bus.req1_valid = 1'b1; bus.req1_addr = a; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      chk($sformatf("req%0d_timeout", n), 0, 1);
    end else begin
      @(posedge clk);
      if (push) begin
        if (n == 0) exp0.push_back(d);
        else        exp1.push_back(d);
      end
    end
    #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !busy) break;
    end
    chk("drain_q0", exp0.size(), 0);
    chk("drain_q1", exp1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t, t0, t1, ta, tb;
    bit ok;
    rom = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    bus.req0_valid = 0; bus.req0_addr = '0; bus.rsp0_ready = 1;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.rsp1_ready = 1;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(posedge clk); #1;

    // Single read: addr 3 -> 11, rsp at t+3, busy t+1..t+3
    send(0, 3'd3, 3, 1, t);
    ok = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (!busy || bus.rsp1_valid) ok = 0;
      if (k < 3 && bus.rsp0_valid) ok = 0;
      if (k == 3) chk("single_latency", bus.rsp0_valid ? cyc - t : -1, 3);
    end
    chk("single_busy_rsp1", ok, 1);
    @(posedge clk); #1;
    drain();

    // Reset during CAPTURE aborts the read
    send(0, 3'd5, 2, 0, t);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rom_addr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid || busy) ok = 0;
    end
    chk("abort_no_rsp", ok, 1);
    @(posedge clk); #1;

    // Contention from reset state: grants alternate 0,1,0,1,...
    got_order.delete();
    fork
      begin
        send(0, 3'd1, 1, 1, t0);
        send(0, 3'd2, 2, 1, t0);
        send(0, 3'd3, 3, 1, t0);
        send(0, 3'd4, 3, 1, t0);
      end
      begin
        send(1, 3'd6, 1, 1, t1);
        send(1, 3'd5, 2, 1, t1);
        send(1, 3'd0, 0, 1, t1);
        send(1, 3'd7, 0, 1, t1);
      end
    join
    drain();
    chk("order_len", got_order.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("order_%0d", i), (i < got_order.size()) ? got_order[i] : -1, i % 2);

    // Backpressure on rsp1; req0 waits until the cycle after the rsp1 handshake
    bus.rsp1_ready = 1'b0;
    send(1, 3'd2, 2, 1, t1);
    fork
      send(0, 3'd7, 0, 1, t0);
      begin
        repeat (2) @(negedge clk);
        ok = 1;
        repeat (5) begin
          @(negedge clk);
          if (!bus.rsp1_valid || bus.rsp1_data != 2'd2 || bus.req0_ready || bus.rsp0_valid) ok = 0;
        end
        chk("bp_hold", ok, 1);
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b1;
      end
    join
    chk("bp_req0_accept", t0, last_hs1 + 1);
    drain();

    // Lone requester 1: addresses 0 then 7, accepted 4 cycles apart
    r0_seen = 0;
    send(1, 3'd0, 0, 1, ta);
    send(1, 3'd7, 0, 1, tb);
    chk("lone_spacing", tb - ta, 4);
    drain();
    chk("lone_req0_ready", r0_seen, 0);

    // Stall hold: req0 raised during ISSUE, rom_addr frozen until IDLE
    send(0, 3'd4, 3, 1, ta);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 3'd2;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.req0_ready || rom_addr != 3'd4) ok = 0;
    end
    chk("stall_hold", ok, 1);
    send(0, 3'd2, 2, 1, tb);
    chk("stall_spacing", tb - ta, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
